// File: rtl/regfile_pkg.sv
// Shared defaults and helpers for the scoreboarded register file.
package regfile_pkg;

  localparam int unsigned DEF_DATA_W = 32;
  localparam int unsigned DEF_ADDR_W = 5;
  localparam int unsigned REG_ZERO   = 0;

  // LSB of port 'port' inside a flat bus of 'width'-bit lanes.
  function automatic int unsigned rd_lsb(input int unsigned port, input int unsigned width);
    return port * width;
  endfunction

endpackage

// File: rtl/rf_pend_ctr.sv
// Saturating up/down in-flight write counter for one register.
module rf_pend_ctr #(
  parameter int unsigned PEND_W = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              inc,
  input  logic              dec,
  output logic [PEND_W-1:0] cnt,
  output logic              full_c,
  output logic              nz_after_dec_c
);

  localparam logic [PEND_W-1:0] MAX = '1;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (inc && !dec && (cnt != MAX)) begin
      cnt <= cnt + PEND_W'(1);
    end else if (dec && !inc && (cnt != '0)) begin
      cnt <= cnt - PEND_W'(1);
    end
  end

  assign full_c = (cnt == MAX);

  // Still outstanding once this cycle's writeback (if any) retires.
  assign nz_after_dec_c = (cnt > PEND_W'(1)) || ((cnt == PEND_W'(1)) && !dec);

endmodule

// File: rtl/regfile_sb.sv
// Multi-port register file with write-to-read bypass and per-register
// in-flight write counters for RAW hazard detection at decode.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W   = DEF_DATA_W,
  parameter int unsigned ADDR_W   = DEF_ADDR_W,
  parameter int unsigned NUM_RD   = 2,
  parameter int unsigned PEND_W   = 2,
  parameter bit          ZERO_REG = 1'b1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_RD*ADDR_W-1:0] adr,
  output logic [NUM_RD*DATA_W-1:0] ReadData,
  output logic [NUM_RD-1:0]        rd_pending,
  input  logic                     issue_valid,
  input  logic [ADDR_W-1:0]        issue_adr,
  output logic                     issue_ready,
  input  logic                     RegWrite,
  input  logic [ADDR_W-1:0]        writeadr,
  input  logic [DATA_W-1:0]        WriteData
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PEND_W-1:0] cnt [DEPTH];
  logic [DEPTH-1:0]  inc;
  logic [DEPTH-1:0]  dec;
  logic [DEPTH-1:0]  full_c;
  logic [DEPTH-1:0]  nz_c;
  logic              issue_fire;
  logic              wr_drop;

  assign wr_drop     = ZERO_REG && (writeadr == ADDR_W'(REG_ZERO));
  assign issue_ready = !reset && !full_c[issue_adr];
  assign issue_fire  = issue_valid && issue_ready;

  // Storage: clock-edge write, zero register writes discarded.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem[i] <= '0;
      end
    end else if (RegWrite && !wr_drop) begin
      mem[writeadr] <= WriteData;
    end
  end

  for (genvar r = 0; r < int'(DEPTH); r++) begin : g_ctr
    // Issues to the hardwired zero register are accepted but never counted.
    assign inc[r] = issue_fire && (issue_adr == ADDR_W'(r))
                    && !(ZERO_REG && (ADDR_W'(r) == ADDR_W'(REG_ZERO)));
    assign dec[r] = RegWrite && (writeadr == ADDR_W'(r)) && (cnt[r] != '0);

    rf_pend_ctr #(
      .PEND_W (PEND_W)
    ) u_ctr (
      .clk            (clk),
      .reset          (reset),
      .inc            (inc[r]),
      .dec            (dec[r]),
      .cnt            (cnt[r]),
      .full_c         (full_c[r]),
      .nz_after_dec_c (nz_c[r])
    );
  end

  for (genvar p = 0; p < int'(NUM_RD); p++) begin : g_rd
    logic [ADDR_W-1:0] a;
    logic              is_zero;
    logic              byp;

    assign a       = adr[rd_lsb(p, ADDR_W) +: ADDR_W];
    assign is_zero = ZERO_REG && (a == ADDR_W'(REG_ZERO));
    assign byp     = RegWrite && (writeadr == a);

    // Reset forces zeros; the bypass covers a write landing this cycle.
    assign ReadData[rd_lsb(p, DATA_W) +: DATA_W] =
      (reset || is_zero) ? '0 : (byp ? WriteData : mem[a]);
    assign rd_pending[p] = !reset && !is_zero && nz_c[a];
  end

endmodule
